// File: rtl/alu64.sv
// alu64 - 64-bit integer ALU with a registered output stage.
//
// Computes the operation selected by alu_control on first_input (A) and
// second_input (B), and captures the result plus a zero flag on the rising
// clock edge when in_valid is high. One cycle of latency, no stall.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   first_input   operand A
//   second_input  operand B (shifts use only the low log2(WIDTH) bits)
//   alu_control   4-bit operation select
//   in_valid      operands/control valid this cycle
//   alu_result    registered result
//   zero          registered flag, 1 when alu_result == 0
//   out_valid     alu_result/zero were captured from a valid input last edge
module alu64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] first_input,
  input  logic [WIDTH-1:0] second_input,
  input  logic [3:0]       alu_control,
  input  logic             in_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             out_valid
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } op_e;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;

  assign shamt = second_input[SHW-1:0];

  always_comb begin
    result = '0;
    case (alu_control)
      OP_AND:  result = first_input & second_input;
      OP_OR:   result = first_input | second_input;
      OP_ADD:  result = first_input + second_input;
      OP_SUB:  result = first_input - second_input;
      OP_XOR:  result = first_input ^ second_input;
      OP_NOR:  result = ~(first_input | second_input);
      OP_SLT:  result[0] = ($signed(first_input) < $signed(second_input));
      OP_SLTU: result[0] = (first_input < second_input);
      OP_SLL:  result = first_input << shamt;
      OP_SRL:  result = first_input >> shamt;
      OP_SRA:  result = WIDTH'($signed(first_input) >>> shamt);
      default: result = '0;
    endcase
  end

  // zero is derived from the same value being captured, so it always
  // agrees with alu_result, including across hold cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result <= '0;
      zero       <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result <= result;
        zero       <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu64.sv
// tb_alu64 - self-checking bench for alu64: directed vector table, hold and
// asynchronous reset sequences, then randomized traffic against a model.
module tb_alu64;

  logic        clk;
  logic        rst;
  logic [63:0] first_input;
  logic [63:0] second_input;
  logic [3:0]  alu_control;
  logic        in_valid;
  logic [63:0] alu_result;
  logic        zero;
  logic        out_valid;

  int unsigned tests;
  int unsigned fails;

  alu64 #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .first_input  (first_input),
    .second_input (second_input),
    .alu_control  (alu_control),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .zero         (zero),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
  } vec_t;

  // Reference model written from the operation rules: shifts as
  // multiplication/division by powers of two, sign handling explicit.
  function automatic logic [63:0] ref_alu(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [3:0]  op);
    logic [63:0] p;
    int          s;
    s = int'(b % 64);
    p = 64'd1 << s;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a + (~b + 64'd1);
      4'd3:  return a ^ b;
      4'd12: return ~(a | b);
      4'd7: begin
        if (a[63] != b[63]) return a[63] ? 64'd1 : 64'd0;
        return (a < b) ? 64'd1 : 64'd0;
      end
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd4:  return a * p;
      4'd5:  return a / p;
      4'd8:  return a[63] ? ~((~a) / p) : a / p;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check64(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] op, input logic v);
    @(negedge clk);
    first_input  = a;
    second_input = b;
    alu_control  = op;
    in_valid     = v;
  endtask

  vec_t vecs[$];
  logic [63:0] exp_res;
  logic        exp_out_valid;
  logic [63:0] held;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    first_input = '0;
    second_input = '0;
    alu_control = '0;
    in_valid = 1'b0;

    #1;
    check64("reset_result", alu_result, 64'd0);
    check1("reset_zero", zero, 1'b1);
    check1("reset_valid", out_valid, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"and_9",     64'hB, 64'hD, 4'b0000, 64'h9});
    vecs.push_back('{"and_0",     64'hB, 64'h4, 4'b0000, 64'h0});
    vecs.push_back('{"or",        64'h9, 64'hC, 4'b0001, 64'hD});
    vecs.push_back('{"add",       64'h6, 64'h5, 4'b0010, 64'hB});
    vecs.push_back('{"add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h0});
    vecs.push_back('{"sub",       64'd7, 64'd3, 4'b0110, 64'd4});
    vecs.push_back('{"sub_eq",    64'd7, 64'd7, 4'b0110, 64'd0});
    vecs.push_back('{"sub_wrap",  64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"xor",       64'hF0F0, 64'h0FF0, 4'b0011, 64'hFF00});
    vecs.push_back('{"nor",       64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_0000, 4'b1100, 64'h0000_0000_0000_FFFF});
    vecs.push_back('{"slt",       64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0111, 64'd1});
    vecs.push_back('{"slt_pos",   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 64'd0});
    vecs.push_back('{"sltu",      64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 64'd0});
    vecs.push_back('{"sltu_lt",   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001, 64'd1});
    vecs.push_back('{"sra_63",    64'h8000_0000_0000_0000, 64'd63, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"sra_pos",   64'h4000_0000_0000_0000, 64'd4, 4'b1000, 64'h0400_0000_0000_0000});
    vecs.push_back('{"srl_63",    64'h8000_0000_0000_0000, 64'd63, 4'b0101, 64'd1});
    vecs.push_back('{"sll_0x40",  64'd1, 64'h40, 4'b0100, 64'd1});
    vecs.push_back('{"sll_5",     64'd3, 64'hFFC5, 4'b0100, 64'h60});
    vecs.push_back('{"undef_f",   64'h1234, 64'h5678, 4'b1111, 64'd0});
    vecs.push_back('{"undef_a",   64'h1234, 64'h5678, 4'b1010, 64'd0});

    // Back-to-back valid inputs: one new result per edge.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
      @(posedge clk);
      #1;
      check64({vecs[i].name, "_result"}, alu_result, vecs[i].res);
      check1({vecs[i].name, "_zero"}, zero, vecs[i].res == 64'd0);
      check1({vecs[i].name, "_valid"}, out_valid, 1'b1);
    end

    // Hold: capture 0xD, then invalid cycles with changing inputs.
    drive(64'h9, 64'hC, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    check64("hold_capture", alu_result, 64'hD);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 64'd0, 4'b0110, 1'b0);
      @(posedge clk);
      #1;
      check64("hold_result", alu_result, 64'hD);
      check1("hold_zero", zero, 1'b0);
      check1("hold_valid", out_valid, 1'b0);
    end

    // Asynchronous reset between edges while holding 0x9.
    drive(64'hB, 64'hD, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check64("pre_reset", alu_result, 64'h9);
    #2;
    rst = 1'b1;
    #1;
    check64("async_rst_result", alu_result, 64'd0);
    check1("async_rst_zero", zero, 1'b1);
    check1("async_rst_valid", out_valid, 1'b0);
    // Valid ADD presented while reset held must be discarded.
    drive(64'd2, 64'd3, 4'b0010, 1'b1);
    @(posedge clk);
    #1;
    check64("rst_held_result", alu_result, 64'd0);
    check1("rst_held_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check64("post_rst_add", alu_result, 64'd5);
    check1("post_rst_zero", zero, 1'b0);
    check1("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic against the model.
    held = alu_result;
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  op;
      logic        v;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 4'($urandom_range(15, 0));
      v  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(4, 0) == 0) b = b & 64'h3F;
      if ($urandom_range(5, 0) == 0) b = a;
      drive(a, b, op, v);
      if (v) held = ref_alu(a, b, op);
      exp_res = held;
      exp_out_valid = v;
      @(posedge clk);
      #1;
      check64("rand_result", alu_result, exp_res);
      check1("rand_zero", zero, exp_res == 64'd0);
      check1("rand_valid", out_valid, exp_out_valid);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
